// File: rtl/if_id_skid_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_skid_buffer_pkg
// Description : Shared IF/ID pipeline types and constants.
// Revision    : 1.0 - initial release
// ============================================================================
package if_id_skid_buffer_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic            valid;
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
    } entry_t;

    // Occupancy decoded from {skid_valid, main_valid}
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_BAD   = 2'd2,
        ST_FULL  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/if_id_entry_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_entry_reg
// Description : One IF/ID entry register with clear and load (reset > clr > load).
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_entry_reg #(
    parameter int          XLEN      = if_id_skid_buffer_pkg::XLEN,
    parameter logic [31:0] NOP_INSTR = if_id_skid_buffer_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            load,
    input  logic [31:0]     d_instr,
    input  logic [XLEN-1:0] d_pc,
    input  logic [XLEN-1:0] d_pc_plus4,
    output logic            q_valid,
    output logic [31:0]     q_instr,
    output logic [XLEN-1:0] q_pc,
    output logic [XLEN-1:0] q_pc_plus4
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_valid    <= 1'b0;
            q_instr    <= NOP_INSTR;
            q_pc       <= '0;
            q_pc_plus4 <= '0;
        end else if (clr) begin
            q_valid    <= 1'b0;
        end else if (load) begin
            q_valid    <= 1'b1;
            q_instr    <= d_instr;
            q_pc       <= d_pc;
            q_pc_plus4 <= d_pc_plus4;
        end
    end

endmodule
`default_nettype wire

// File: rtl/if_id_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : if_id_skid_buffer
// Description : IF/ID boundary, 2-entry skid buffer with registered in_ready.
//               Optional IFID_STALL_COUNT_EN adds the stall_cycles counter.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_skid_buffer #(
    parameter int          XLEN      = if_id_skid_buffer_pkg::XLEN,
    parameter logic [31:0] NOP_INSTR = if_id_skid_buffer_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_pc_plus4,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
`ifdef IFID_STALL_COUNT_EN
    output logic [31:0]     stall_cycles,
`endif
    output logic [XLEN-1:0] out_pc_plus4
);

    import if_id_skid_buffer_pkg::*;

    logic            main_valid, skid_valid;
    logic [31:0]     main_instr, skid_instr;
    logic [XLEN-1:0] main_pc, skid_pc, main_pc_plus4, skid_pc_plus4;

    logic            ready_q;
    logic            accept, drain;
    logic            main_clr, main_load, skid_to_main;
    logic            skid_clr, skid_load, skid_valid_nxt;
    logic [31:0]     main_d_instr;
    logic [XLEN-1:0] main_d_pc, main_d_pc_plus4;
    state_t          state;

    assign in_ready = ready_q & rst_n;
    assign accept   = in_valid & in_ready;
    assign drain    = main_valid & out_ready;

    always_comb begin
        state = ST_EMPTY;
        case ({skid_valid, main_valid})
            2'b01:   state = ST_ONE;
            2'b11:   state = ST_FULL;
            2'b10:   state = ST_BAD;
            default: state = ST_EMPTY;
        endcase
    end

    always_comb begin
        main_clr       = 1'b0;
        main_load      = 1'b0;
        skid_to_main   = 1'b0;
        skid_clr       = 1'b0;
        skid_load      = 1'b0;
        skid_valid_nxt = skid_valid;
        if (flush) begin
            main_clr       = 1'b1;
            skid_clr       = 1'b1;
            skid_valid_nxt = 1'b0;
        end else begin
            case (state)
                ST_EMPTY: main_load = accept;
                ST_ONE: begin
                    if (accept && drain) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        skid_load      = 1'b1;
                        skid_valid_nxt = 1'b1;
                    end else if (drain) begin
                        main_clr = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        main_load      = 1'b1;
                        skid_to_main   = 1'b1;
                        skid_clr       = 1'b1;
                        skid_valid_nxt = 1'b0;
                    end
                end
                default: begin
                    main_clr       = 1'b1;
                    skid_clr       = 1'b1;
                    skid_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    assign main_d_instr    = skid_to_main ? skid_instr    : in_instr;
    assign main_d_pc       = skid_to_main ? skid_pc       : in_pc;
    assign main_d_pc_plus4 = skid_to_main ? skid_pc_plus4 : in_pc_plus4;

    if_id_entry_reg #(.XLEN(XLEN), .NOP_INSTR(NOP_INSTR)) u_main (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (main_clr),
        .load       (main_load),
        .d_instr    (main_d_instr),
        .d_pc       (main_d_pc),
        .d_pc_plus4 (main_d_pc_plus4),
        .q_valid    (main_valid),
        .q_instr    (main_instr),
        .q_pc       (main_pc),
        .q_pc_plus4 (main_pc_plus4)
    );

    if_id_entry_reg #(.XLEN(XLEN), .NOP_INSTR(NOP_INSTR)) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (skid_clr),
        .load       (skid_load),
        .d_instr    (in_instr),
        .d_pc       (in_pc),
        .d_pc_plus4 (in_pc_plus4),
        .q_valid    (skid_valid),
        .q_instr    (skid_instr),
        .q_pc       (skid_pc),
        .q_pc_plus4 (skid_pc_plus4)
    );

    // in_ready tracks next-cycle skid occupancy so it never depends on out_ready combinationally
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_q <= 1'b1;
        end else begin
            ready_q <= ~skid_valid_nxt;
        end
    end

    assign out_valid    = main_valid;
    assign out_instr    = main_valid ? main_instr    : NOP_INSTR;
    assign out_pc       = main_valid ? main_pc       : '0;
    assign out_pc_plus4 = main_valid ? main_pc_plus4 : '0;

`ifdef IFID_STALL_COUNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (main_valid && !out_ready) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule
`default_nettype wire

// File: doc/if_id_skid_buffer.md
Name: if_id_skid_buffer

Overview:
- Pipeline boundary between instruction fetch and decode.
- Registers the fetched instruction and its PC/PC+4 under a valid/ready handshake.
- Holds a 2-entry skid so that fetch never stalls combinationally on decode backpressure.
- Output instruction bits feed the decode stage's register-file addressing and immediate extender (instr[31:7]). Branch/jump redirect from EX flushes it.

Parameters:
XLEN, 32, width of pc and pc_plus4 fields.
NOP_INSTR, 32'h0000_0013, instruction driven on out_instr whenever out_valid=0 (addi x0,x0,0 bubble).

Ports:
clk  input  1  single clock, all state updates on rising edge.
rst_n  input  1  synchronous active-low reset, sampled on clk rising edge.
flush  input  1  discard all held and incoming entries (EX redirect).
in_valid  input  1  fetch presents instruction.
in_ready  output  1  buffer can accept; registered, equals !skid_valid.
in_instr  input  32  fetched instruction.
in_pc  input  XLEN  PC of in_instr.
in_pc_plus4  input  XLEN  in_pc+4 from fetch adder.
out_valid  output  1  decode entry valid.
out_ready  input  1  decode consumes this cycle.
out_instr  output  32  instruction to decode; NOP_INSTR when !out_valid.
out_pc  output  XLEN  PC of out_instr; 0 when !out_valid.
out_pc_plus4  output  XLEN  PC+4 of out_instr; 0 when !out_valid.

Behaviour:
- Storage: main entry (drives outputs), skid entry; each {valid, instr, pc, pc_plus4}.
- States, derived from valid bits:
  - EMPTY: main=0, skid=0.
  - ONE: main=1, skid=0.
  - FULL: main=1, skid=1. Skid valid without main valid is illegal.
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- Transitions:
  - EMPTY + accept -> ONE; input goes to main.
  - ONE + accept & drain -> ONE; input replaces main.
  - ONE + accept & !drain -> FULL; input goes to skid.
  - ONE + drain & !accept -> EMPTY.
  - FULL + drain -> ONE; skid moves to main, skid cleared. in_ready=0 in FULL, so no accept.
  - No accept and no drain: hold.
- Latency: input accepted at edge N appears on outputs after edge N (1 cycle) when entering EMPTY or ONE with drain. Order is strictly FIFO.
- in_ready is purely registered. No combinational path from out_ready to in_ready, or from in_* to out_*.
- flush=1 at an edge: both valids cleared, any accept in that cycle discarded, state -> EMPTY. Flush overrides a simultaneous accept and drain. The drain still counts as consumed by decode.
- rst_n=0 at an edge: valids cleared, data fields cleared (instr=NOP_INSTR, pc=0). While rst_n=0, in_ready is forced to 0. Reset overrides flush. Reset mid-FULL loses both entries.
- Outputs after reset: in_ready=1 (once rst_n=1), out_valid=0, out_instr=NOP_INSTR, out_pc=0, out_pc_plus4=0.
- Data fields of an invalid entry are don't-care internally. The output mux forces the bubble values.
- in_* are not checked. pc_plus4 is passed through without recomputation, with no overflow handling.

Optional Feature:
- Macro IFID_STALL_COUNT_EN.
- Defined: adds output stall_cycles [31:0]. It counts cycles with out_valid=1 & out_ready=0, wraps at 2^32-1 -> 0, and is cleared by reset but not by flush.
- Undefined: port and counter absent. Behaviour is otherwise identical.

Decomposition:
- Shared pipeline package holds:
  - NOP_INSTR constant.
  - Entry struct typedef {valid, instr, pc, pc_plus4}.
  - XLEN default.
- One natural sub-module: if_id_entry_reg, a single clear/load entry register, instantiated twice (main, skid).
- State machine and output mux stay in the top.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> in_ready=0 and out_valid=0. After release: out_instr=32'h00000013, out_pc=0, in_ready=1.
- Streaming: out_ready=1, push pc 0x100/0x104/0x108 on consecutive cycles -> each appears 1 cycle later in order. in_ready stays 1.
- Backpressure: out_ready=0, push 0x200 then 0x204 -> FULL, in_ready=0, out_pc=0x200 held. Raise out_ready -> 0x200 then 0x204 drained, in_ready back to 1 after the first drain.
- Flush in FULL with simultaneous in_valid (pc 0x300) and out_ready=1 -> next cycle out_valid=0, out_instr=NOP_INSTR, 0x300 never emitted.
- Reset mid-operation: FULL state, drop rst_n for 1 cycle -> EMPTY, no stale entry emitted after release.
- IFID_STALL_COUNT_EN: hold out_valid=1, out_ready=0 for 5 cycles -> stall_cycles=5. A flush leaves it at 5. Preload near 32'hFFFFFFFF to check wrap to 0.
